// File: rtl/demux_stream_nch.sv
// Single-slot stream demultiplexer: one registered payload is routed to one of
// NUM_CH outputs, chosen by in_sel (directed) or by a round-robin pointer.
module demux_stream_nch #(
    parameter int DATA_W = 8,
    parameter int NUM_CH = 4,
    parameter int SEL_W  = $clog2(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mode,
    input  logic [DATA_W-1:0] in_data,
    input  logic [SEL_W-1:0]  in_sel,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [NUM_CH-1:0] out_valid,
    input  logic [NUM_CH-1:0] out_ready,
    output logic [SEL_W-1:0]  rr_ptr,
    output logic [15:0]       drop_cnt
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    localparam logic [SEL_W-1:0] LAST_CH  = SEL_W'(NUM_CH - 1);
    localparam logic [SEL_W:0]   CH_LIMIT = (SEL_W + 1)'(NUM_CH);

    state_t            state_reg, state_next;
    logic [DATA_W-1:0] data_reg, data_next;
    logic [SEL_W-1:0]  held_ch_reg, held_ch_next;
    logic [SEL_W-1:0]  rr_ptr_reg, rr_ptr_next;
    logic [15:0]       drop_cnt_reg, drop_cnt_next;

    logic [NUM_CH-1:0] ch_hit;
    logic              held_ready;
    logic [SEL_W-1:0]  target;
    logic              target_ok;
    logic              accept;
    logic              in_xfer;
    logic              out_xfer;
    logic              load;
    logic              drop;

    // Decode of the held channel; only its out_ready bit matters.
    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            assign ch_hit[gi] = (held_ch_reg == SEL_W'(gi));
        end
    endgenerate

    assign held_ready = |(ch_hit & out_ready);
    assign target     = mode ? rr_ptr_reg : in_sel;
    assign target_ok  = ({1'b0, target} < CH_LIMIT);
    assign accept     = !rst && ((state_reg == EMPTY) || held_ready);
    assign in_xfer    = in_valid && accept;
    assign out_xfer   = (state_reg == FULL) && held_ready;
    assign load       = in_xfer && target_ok;
    assign drop       = in_xfer && !target_ok;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= EMPTY;
            data_reg     <= '0;
            held_ch_reg  <= '0;
            rr_ptr_reg   <= '0;
            drop_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            data_reg     <= data_next;
            held_ch_reg  <= held_ch_next;
            rr_ptr_reg   <= rr_ptr_next;
            drop_cnt_reg <= drop_cnt_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        data_next     = data_reg;
        held_ch_next  = held_ch_reg;
        rr_ptr_next   = rr_ptr_reg;
        drop_cnt_next = drop_cnt_reg;

        // A load wins over a drain, so back-to-back streaming has no bubble;
        // a discard that coincides with a drain still empties the slot.
        if (load) begin
            state_next   = FULL;
            data_next    = in_data;
            held_ch_next = target;
        end else if (out_xfer) begin
            state_next = EMPTY;
        end

        if (load && mode) begin
            rr_ptr_next = (rr_ptr_reg == LAST_CH) ? '0 : rr_ptr_reg + SEL_W'(1);
        end

        if (drop && (drop_cnt_reg != 16'hFFFF)) begin
            drop_cnt_next = drop_cnt_reg + 16'd1;
        end
    end

    always_comb begin
        out_valid = '0;
        if (state_reg == FULL) begin
            out_valid = ch_hit;
        end
        in_ready = accept;
        out_data = data_reg;
        rr_ptr   = rr_ptr_reg;
        drop_cnt = drop_cnt_reg;
    end

endmodule

// File: tb/tb_demux_stream_nch.sv
// Self-checking bench for demux_stream_nch: directed vector table, multi-cycle
// scenarios and a payload scoreboard on the 4-channel instance.
module tb_demux_stream_nch;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       mode = 1'b0;
    logic [7:0] in_data = '0;
    logic [1:0] in_sel = '0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] out_data;
    logic [3:0] out_valid;
    logic [3:0] out_ready = '0;
    logic [1:0] rr_ptr;
    logic [15:0] drop_cnt;

    logic       d3_mode = 1'b0;
    logic [7:0] d3_data = '0;
    logic [1:0] d3_sel = '0;
    logic       d3_valid = 1'b0;
    logic       d3_ready;
    logic [7:0] d3_out_data;
    logic [2:0] d3_out_valid;
    logic [2:0] d3_out_ready = '0;
    logic [1:0] d3_rr;
    logic [15:0] d3_drop;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    demux_stream_nch #(.DATA_W(8), .NUM_CH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .rr_ptr    (rr_ptr),
        .drop_cnt  (drop_cnt)
    );

    demux_stream_nch #(.DATA_W(8), .NUM_CH(3)) dut3 (
        .clk       (clk),
        .rst       (rst),
        .mode      (d3_mode),
        .in_data   (d3_data),
        .in_sel    (d3_sel),
        .in_valid  (d3_valid),
        .in_ready  (d3_ready),
        .out_data  (d3_out_data),
        .out_valid (d3_out_valid),
        .out_ready (d3_out_ready),
        .rr_ptr    (d3_rr),
        .drop_cnt  (d3_drop)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end else begin
            $display("ok   %s: 0x%0h at %0t", name, act, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    function automatic int onehot_idx(input logic [3:0] v);
        for (int i = 0; i < 4; i++) begin
            if (v[i]) return i;
        end
        return -1;
    endfunction

    // Scoreboard: expected {channel, payload} pushed on accepted input,
    // popped when an output transfer is about to happen.
    typedef struct {
        int         ch;
        logic [7:0] data;
    } exp_t;

    exp_t sb[$];
    int   tb_rr = 0;

    always @(negedge clk) begin
        exp_t e;
        int   tgt;
        if (rst) begin
            sb.delete();
            tb_rr = 0;
        end else begin
            chk("onehot", 32'($countones(out_valid) <= 1), 32'd1);
            if ((out_valid & out_ready) != 4'b0) begin
                chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("sb_ch", 32'(onehot_idx(out_valid)), 32'(e.ch));
                    chk("sb_data", 32'(out_data), 32'(e.data));
                end
            end
            if (in_valid && in_ready) begin
                tgt = mode ? tb_rr : int'(in_sel);
                sb.push_back('{tgt, in_data});
                if (mode) tb_rr = (tb_rr == 3) ? 0 : tb_rr + 1;
            end
        end
    end

    typedef struct {
        logic       md;
        logic [1:0] sel;
        logic [7:0] data;
        logic [3:0] exp_valid;
        logic [1:0] exp_rr;
    } vec_t;

    vec_t vecs[8];

    initial begin
        vecs[0] = '{1'b0, 2'd2, 8'hA5, 4'b0100, 2'd0};
        vecs[1] = '{1'b0, 2'd0, 8'h11, 4'b0001, 2'd0};
        vecs[2] = '{1'b1, 2'd3, 8'h22, 4'b0001, 2'd1};
        vecs[3] = '{1'b1, 2'd0, 8'h33, 4'b0010, 2'd2};
        vecs[4] = '{1'b0, 2'd3, 8'h44, 4'b1000, 2'd2};
        vecs[5] = '{1'b1, 2'd1, 8'h55, 4'b0100, 2'd3};
        vecs[6] = '{1'b1, 2'd2, 8'h66, 4'b1000, 2'd0};
        vecs[7] = '{1'b0, 2'd1, 8'h77, 4'b0010, 2'd0};

        // Reset state
        tick();
        sample();
        chk("in_ready_in_rst", 32'(in_ready), 32'd0);
        chk("d3_ready_in_rst", 32'(d3_ready), 32'd0);
        tick();
        rst = 1'b0;
        sample();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_rr_ptr", 32'(rr_ptr), 32'd0);
        chk("rst_drop_cnt", 32'(drop_cnt), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_d3_drop", 32'(d3_drop), 32'd0);

        // Directed vectors: load, hold under backpressure, drain
        for (int i = 0; i < 8; i++) begin
            tick();
            mode = vecs[i].md;
            in_sel = vecs[i].sel;
            in_data = vecs[i].data;
            in_valid = 1'b1;
            out_ready = 4'b0;
            sample();
            chk("vec_in_ready_empty", 32'(in_ready), 32'd1);
            tick();
            in_valid = 1'b0;
            sample();
            chk("vec_out_valid", 32'(out_valid), 32'(vecs[i].exp_valid));
            chk("vec_out_data", 32'(out_data), 32'(vecs[i].data));
            chk("vec_in_ready_full", 32'(in_ready), 32'd0);
            chk("vec_rr_ptr", 32'(rr_ptr), 32'(vecs[i].exp_rr));
            out_ready = ~vecs[i].exp_valid;
            tick();
            tick();
            sample();
            chk("vec_hold_valid", 32'(out_valid), 32'(vecs[i].exp_valid));
            chk("vec_hold_ready", 32'(in_ready), 32'd0);
            tick();
            out_ready = vecs[i].exp_valid;
            sample();
            chk("vec_drain_ready", 32'(in_ready), 32'd1);
            tick();
            out_ready = 4'b0;
            sample();
            chk("vec_empty_valid", 32'(out_valid), 32'd0);
            chk("vec_data_kept", 32'(out_data), 32'(vecs[i].data));
        end

        // Streaming round-robin with no bubbles
        tick();
        do_reset();
        mode = 1'b1;
        out_ready = 4'hF;
        in_valid = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            in_data = 8'(k);
            sample();
            chk("stream_in_ready", 32'(in_ready), 32'd1);
            if (k > 1) begin
                chk("stream_valid", 32'(out_valid), 32'(4'b0001 << ((k - 2) % 4)));
                chk("stream_data", 32'(out_data), 32'(k - 1));
            end
            tick();
        end
        in_valid = 1'b0;
        sample();
        chk("stream_last_valid", 32'(out_valid), 32'd1);
        chk("stream_last_data", 32'(out_data), 32'd5);
        chk("stream_rr_end", 32'(rr_ptr), 32'd1);
        tick();

        // Backpressure on channel 1, mode toggled while held
        do_reset();
        mode = 1'b0;
        in_sel = 2'd1;
        in_data = 8'h11;
        in_valid = 1'b1;
        out_ready = 4'b1101;
        sample();
        chk("bp_in_ready", 32'(in_ready), 32'd1);
        tick();
        in_sel = 2'd3;
        in_data = 8'h22;
        for (int i = 0; i < 3; i++) begin
            mode = i[0];
            sample();
            chk("bp_stall_valid", 32'(out_valid), 32'b0010);
            chk("bp_stall_data", 32'(out_data), 32'h11);
            chk("bp_stall_ready", 32'(in_ready), 32'd0);
            tick();
        end
        mode = 1'b0;
        out_ready = 4'hF;
        sample();
        chk("bp_release_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        sample();
        chk("bp_new_valid", 32'(out_valid), 32'b1000);
        chk("bp_new_data", 32'(out_data), 32'h22);
        tick();
        out_ready = 4'b0;

        // Reset while holding 8'h3C on channel 3 with rr_ptr=2
        do_reset();
        out_ready = 4'hF;
        mode = 1'b1;
        in_valid = 1'b1;
        in_data = 8'h01;
        tick();
        in_data = 8'h02;
        tick();
        mode = 1'b0;
        in_sel = 2'd3;
        in_data = 8'h3C;
        tick();
        in_valid = 1'b0;
        out_ready = 4'b0;
        sample();
        chk("rs_held_valid", 32'(out_valid), 32'b1000);
        chk("rs_held_data", 32'(out_data), 32'h3C);
        chk("rs_held_rr", 32'(rr_ptr), 32'd2);
        rst = 1'b1;
        in_valid = 1'b1;
        in_sel = 2'd0;
        in_data = 8'h77;
        sample();
        chk("rs_in_ready_rst", 32'(in_ready), 32'd0);
        tick();
        rst = 1'b0;
        sample();
        chk("rs_out_valid", 32'(out_valid), 32'd0);
        chk("rs_out_data", 32'(out_data), 32'd0);
        chk("rs_rr_ptr", 32'(rr_ptr), 32'd0);
        chk("rs_drop_cnt", 32'(drop_cnt), 32'd0);
        chk("rs_in_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        sample();
        chk("rs_first_valid", 32'(out_valid), 32'b0001);
        chk("rs_first_data", 32'(out_data), 32'h77);
        out_ready = 4'hF;
        tick();
        out_ready = 4'b0;

        // Mode switch: rr resumes where it left off
        do_reset();
        out_ready = 4'hF;
        in_valid = 1'b1;
        mode = 1'b1;
        in_data = 8'hA1;
        tick();
        in_data = 8'hA2;
        tick();
        mode = 1'b0;
        in_sel = 2'd0;
        in_data = 8'hA3;
        tick();
        mode = 1'b1;
        in_data = 8'hA4;
        tick();
        in_valid = 1'b0;
        sample();
        chk("ms_valid", 32'(out_valid), 32'b0100);
        chk("ms_data", 32'(out_data), 32'hA4);
        chk("ms_rr", 32'(rr_ptr), 32'd3);
        tick();
        out_ready = 4'b0;

        // Three-channel instance: drops, drop with drain, rr wrap, saturation
        d3_mode = 1'b0;
        d3_sel = 2'd3;
        d3_valid = 1'b1;
        d3_out_ready = 3'b0;
        for (int i = 0; i < 3; i++) begin
            sample();
            chk("d3_drop_ready", 32'(d3_ready), 32'd1);
            chk("d3_drop_valid", 32'(d3_out_valid), 32'd0);
            tick();
        end
        d3_valid = 1'b0;
        sample();
        chk("d3_drop_cnt3", 32'(d3_drop), 32'd3);
        chk("d3_drop_empty", 32'(d3_out_valid), 32'd0);
        tick();
        d3_sel = 2'd1;
        d3_data = 8'h5A;
        d3_valid = 1'b1;
        tick();
        d3_sel = 2'd3;
        d3_out_ready = 3'b010;
        sample();
        chk("d3_dd_valid", 32'(d3_out_valid), 32'b010);
        chk("d3_dd_ready", 32'(d3_ready), 32'd1);
        tick();
        d3_valid = 1'b0;
        d3_out_ready = 3'b0;
        sample();
        chk("d3_dd_empty", 32'(d3_out_valid), 32'd0);
        chk("d3_dd_cnt", 32'(d3_drop), 32'd4);
        chk("d3_dd_data", 32'(d3_out_data), 32'h5A);
        tick();
        d3_mode = 1'b1;
        d3_valid = 1'b1;
        d3_out_ready = 3'b111;
        for (int k = 0; k < 4; k++) begin
            d3_data = 8'(8'hC0 + k);
            tick();
            sample();
            chk("d3_rr_valid", 32'(d3_out_valid), 32'(3'b001 << (k % 3)));
            chk("d3_rr_data", 32'(d3_out_data), 32'(8'hC0 + k));
        end
        d3_valid = 1'b0;
        sample();
        chk("d3_rr_wrap", 32'(d3_rr), 32'd1);
        tick();
        d3_mode = 1'b0;
        d3_sel = 2'd3;
        d3_valid = 1'b1;
        repeat (65540) @(posedge clk);
        #1;
        d3_valid = 1'b0;
        sample();
        chk("d3_drop_sat", 32'(d3_drop), 32'hFFFF);

        sample();
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
